cv32e40p_alu_err_tracker_ft: RTL and testbench
==============================================

# cv32e40p_alu_err_tracker_ft

Parametrised per-unit, per-operation-class leaky-bucket error tracker for the fault-tolerant cv32e40p execute stage. Each of `NUM_UNITS` replicated ALUs reports one checked operation per cycle, tagged with a pre-decoded class index and an error bit. The block keeps one saturating counter per (unit, class), sets a sticky permanent-fault flag when a counter reaches `THRESHOLD`, and emits one-cycle new-fault pulses for the CS-register performance counters. It adds software clear and registered counter readout for diagnostics.

## Interface
- `NUM_UNITS`, 4, number of monitored ALUs (>=1)
- `NUM_CLASSES`, 9, operation classes per unit (>=2)
- `CNT_WIDTH`, 8, counter width in bits
- `INC`, 1, added on an errored operation (>=1)
- `DEC`, 2, subtracted on a clean operation (>=1)
- `THRESHOLD`, 100, count at which a class is declared permanently faulty (1..2^CNT_WIDTH-1)
- `CLASS_W`, derived `$clog2(NUM_CLASSES)`, class index width; not overridable
- `clk`  in  1  clock; the only clock
- `rst`  in  1  synchronous, active-high reset
- `valid_i`  in  NUM_UNITS  unit u executed a checked operation this cycle
- `class_i`  in  NUM_UNITS×CLASS_W  class index of that operation
- `error_i`  in  NUM_UNITS  voter/checker flagged unit u's result as wrong
- `clear_valid_i`  in  1  clear request
- `clear_all_i`  in  1  with `clear_valid_i`: clear every counter and flag
- `clear_unit_i`  in  $clog2(NUM_UNITS) (min 1)  target unit for a single clear
- `clear_class_i`  in  CLASS_W  target class for a single clear
- `rd_unit_i`  in  $clog2(NUM_UNITS) (min 1)  readout unit select
- `rd_class_i`  in  CLASS_W  readout class select
- `rd_count_o`  out  CNT_WIDTH  registered counter value of the selected entry
- `faulty_o`  out  NUM_UNITS×NUM_CLASSES  sticky permanent-fault flags
- `unit_faulty_o`  out  NUM_UNITS  OR of `faulty_o[u]`
- `new_fault_o`  out  NUM_UNITS  one-cycle pulse: unit u got at least one new flag at this edge

## Operation
- Per unit u, each cycle with `valid_i[u]` and `class_i[u] < NUM_CLASSES` updates only entry (u, c = `class_i[u]`). All other entries hold. Invalid or out-of-range class means no update.
- If `faulty_o[u][c]` is set, the entry is frozen: counter and flag hold and the event is ignored.
- Errored operation: `cnt ← min(cnt + INC, 2^CNT_WIDTH-1)`. The sum is computed at CNT_WIDTH+1 bits, then saturated.
- Clean operation: `cnt ← (cnt > DEC) ? cnt - DEC : 0`.
- Flag set at the same edge the counter's next value is ≥ THRESHOLD. The counter keeps that value, frozen.
- `new_fault_o[u]` is registered. It is 1 for exactly the cycle after an edge that set any flag of unit u.
- Clear, evaluated at the edge:
  - `clear_all_i=1` zeroes all counters, flags and `new_fault_o`.
  - Otherwise it zeroes counter and flag of (`clear_unit_i`, `clear_class_i`). Out-of-range indices mean no effect.
- Clear beats a same-cycle event on the same entry: the event is dropped. Events on other entries proceed normally.
- Units are independent. Events on all units in the same cycle update in parallel.
- `rd_count_o` is the registered counter of (`rd_unit_i`, `rd_class_i`), sampled from the pre-edge state. Out-of-range selection gives 0.

## Timing
- Reset (`rst`=1 at an edge): all counters 0, `faulty_o`=0, `unit_faulty_o`=0, `new_fault_o`=0, `rd_count_o`=0.
- Reset asserted mid-accumulation discards all state at that edge. Reset has priority over clear and events.
- Event at edge k: counter and flag are visible after k. `unit_faulty_o` is combinational from the flags, so it is also visible after k. `new_fault_o` is high during cycle k→k+1 only.
- Readout latency is 1 cycle. An update and a read of the same entry at edge k give the pre-update value after k and the updated value after k+1.
- No handshakes: inputs are sampled every edge, with no back-pressure.

## Test plan
- **Reset and defaults:** `rst` for 2 cycles with random inputs, defaults (4,9,8,1,2,100) → all outputs 0; read (3,8) gives 0.
- **Threshold crossing:** 99 errored class-5 ops on unit 2 → count 99, no flag. 100th → `faulty_o[2][5]`=1 and `unit_faulty_o[2]`=1 after that edge. `new_fault_o[2]` is high exactly one cycle. A further 20 errored ops leave the count at 100.
- **Leak and floor:** unit 0 class 1 with 10 errors then 4 clean → count 2. One clean → 0. Another clean → still 0.
- **Saturation:** CNT_WIDTH=4, THRESHOLD=15, INC=6, from count 12 one error → count 15 (not wrap to 2) and flag set.
- **Clear priority and clear-all:** flag (1,3) set. Single clear of (1,3) in the same cycle as an error on unit 1 class 3 → count 0, flag 0, no pulse. Meanwhile unit 0 class 3 still increments. Then `clear_all_i` → every flag and counter 0.
- **Parallel units and out-of-range class:** NUM_CLASSES=9, all 4 units valid in the same cycle with classes 0, 4, 8, 15, all errored → entries (0,0), (1,4), (2,8) become 1. Unit 3 is unchanged.

Source files
------------

// File: rtl/cv32e40p_alu_err_tracker_ft_if.sv
// Error-report bus from the replicated ALU checkers into the error tracker.
// No handshake: the tracker samples every lane on every clock edge and never applies back-pressure.
interface cv32e40p_alu_err_tracker_ft_if #(
  parameter int NUM_UNITS   = 4,
  parameter int NUM_CLASSES = 9
);
  localparam int CLASS_W = $clog2(NUM_CLASSES);

  logic [NUM_UNITS-1:0]              valid_i;
  logic [NUM_UNITS-1:0][CLASS_W-1:0] class_i;
  logic [NUM_UNITS-1:0]              error_i;

  modport master (output valid_i, class_i, error_i);
  modport slave  (input  valid_i, class_i, error_i);
endinterface

// File: rtl/cv32e40p_alu_err_tracker_ft.sv
// Leaky-bucket error tracker: one saturating counter and sticky fault flag per (ALU unit, op class),
// with software clear, one-cycle new-fault pulses and a registered counter readout.
module cv32e40p_alu_err_tracker_ft #(
  parameter int NUM_UNITS   = 4,
  parameter int NUM_CLASSES = 9,
  parameter int CNT_WIDTH   = 8,
  parameter int INC         = 1,
  parameter int DEC         = 2,
  parameter int THRESHOLD   = 100,
  localparam int CLASS_W    = $clog2(NUM_CLASSES),
  localparam int UNIT_W     = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1
) (
  input  logic                                   clk,
  input  logic                                   rst,
  cv32e40p_alu_err_tracker_ft_if.slave           evt,
  input  logic                                   clear_valid_i,
  input  logic                                   clear_all_i,
  input  logic [UNIT_W-1:0]                      clear_unit_i,
  input  logic [CLASS_W-1:0]                     clear_class_i,
  input  logic [UNIT_W-1:0]                      rd_unit_i,
  input  logic [CLASS_W-1:0]                     rd_class_i,
  output logic [CNT_WIDTH-1:0]                   rd_count_o,
  output logic [NUM_UNITS-1:0][NUM_CLASSES-1:0]  faulty_o,
  output logic [NUM_UNITS-1:0]                   unit_faulty_o,
  output logic [NUM_UNITS-1:0]                   new_fault_o
);

  logic [NUM_UNITS-1:0][NUM_CLASSES-1:0][CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [NUM_UNITS-1:0][NUM_CLASSES-1:0]                flag_q, flag_d;
  logic [NUM_UNITS-1:0]                                 new_q, new_d;
  logic [CNT_WIDTH-1:0]                                 rd_q, rd_mux;
  logic [CNT_WIDTH:0]                                   sum;
  logic [CNT_WIDTH-1:0]                                 nxt;
  logic                                                 clr_hit;

  // Each unit touches at most one entry per cycle; a clear on that entry wins over the event.
  always_comb begin
    cnt_d   = cnt_q;
    flag_d  = flag_q;
    new_d   = '0;
    sum     = '0;
    nxt     = '0;
    clr_hit = 1'b0;
    for (int u = 0; u < NUM_UNITS; u++) begin
      for (int c = 0; c < NUM_CLASSES; c++) begin
        clr_hit = clear_valid_i && (clear_all_i ||
                  (clear_unit_i == UNIT_W'(u) && clear_class_i == CLASS_W'(c)));
        if (clr_hit) begin
          cnt_d[u][c]  = '0;
          flag_d[u][c] = 1'b0;
        end else if (evt.valid_i[u] && evt.class_i[u] == CLASS_W'(c) && !flag_q[u][c]) begin
          sum = {1'b0, cnt_q[u][c]} + (CNT_WIDTH+1)'(INC);
          if (evt.error_i[u]) begin
            nxt = sum[CNT_WIDTH] ? '1 : sum[CNT_WIDTH-1:0];
          end else begin
            nxt = (32'(cnt_q[u][c]) > 32'(DEC)) ? CNT_WIDTH'(32'(cnt_q[u][c]) - 32'(DEC)) : '0;
          end
          cnt_d[u][c] = nxt;
          if (32'(nxt) >= 32'(THRESHOLD)) begin
            flag_d[u][c] = 1'b1;
            new_d[u]     = 1'b1;
          end
        end
      end
    end
  end

  // Out-of-range read selects never match and therefore return zero.
  always_comb begin
    rd_mux = '0;
    for (int u = 0; u < NUM_UNITS; u++) begin
      for (int c = 0; c < NUM_CLASSES; c++) begin
        if (rd_unit_i == UNIT_W'(u) && rd_class_i == CLASS_W'(c)) rd_mux = cnt_q[u][c];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      flag_q <= '0;
      new_q  <= '0;
      rd_q   <= '0;
    end else begin
      cnt_q  <= cnt_d;
      flag_q <= flag_d;
      new_q  <= new_d;
      rd_q   <= rd_mux;
    end
  end

  always_comb begin
    for (int u = 0; u < NUM_UNITS; u++) unit_faulty_o[u] = |flag_q[u];
  end

  assign faulty_o    = flag_q;
  assign new_fault_o = new_q;
  assign rd_count_o  = rd_q;

endmodule

// File: tb/tb_cv32e40p_alu_err_tracker_ft.sv
// Bench for the ALU error tracker: directed scenarios plus randomized traffic against an entry-level model.
module tb_cv32e40p_alu_err_tracker_ft;
  localparam int NU = 4, NC = 9, MAXC = 255, M_INC = 1, M_DEC = 2, M_THR = 100;

  logic clk, rst;
  logic clear_valid, clear_all;
  logic [1:0] clear_unit, rd_unit;
  logic [3:0] clear_class, rd_class;
  logic [7:0] rd_count;
  logic [NU-1:0][NC-1:0] faulty;
  logic [NU-1:0] unit_faulty, new_fault;

  cv32e40p_alu_err_tracker_ft_if #(.NUM_UNITS(NU), .NUM_CLASSES(NC)) evt_if ();

  cv32e40p_alu_err_tracker_ft dut (
    .clk(clk), .rst(rst), .evt(evt_if),
    .clear_valid_i(clear_valid), .clear_all_i(clear_all),
    .clear_unit_i(clear_unit), .clear_class_i(clear_class),
    .rd_unit_i(rd_unit), .rd_class_i(rd_class),
    .rd_count_o(rd_count), .faulty_o(faulty),
    .unit_faulty_o(unit_faulty), .new_fault_o(new_fault)
  );

  // Small saturating instance: 4-bit counters, INC=6, THRESHOLD=15.
  logic sat_rd_unit, sat_rd_class;
  logic [3:0] sat_rd;
  logic [1:0][1:0] sat_faulty;
  logic [1:0] sat_uf, sat_new;

  cv32e40p_alu_err_tracker_ft_if #(.NUM_UNITS(2), .NUM_CLASSES(2)) sat_if ();

  cv32e40p_alu_err_tracker_ft #(
    .NUM_UNITS(2), .NUM_CLASSES(2), .CNT_WIDTH(4), .INC(6), .DEC(2), .THRESHOLD(15)
  ) dut_sat (
    .clk(clk), .rst(rst), .evt(sat_if),
    .clear_valid_i(1'b0), .clear_all_i(1'b0), .clear_unit_i(1'b0), .clear_class_i(1'b0),
    .rd_unit_i(sat_rd_unit), .rd_class_i(sat_rd_class),
    .rd_count_o(sat_rd), .faulty_o(sat_faulty),
    .unit_faulty_o(sat_uf), .new_fault_o(sat_new)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: one integer bucket and flag per entry.
  int m_cnt  [NU][NC];
  bit m_flag [NU][NC];
  bit [NU-1:0] m_new;
  int m_rd;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic model_edge();
    int c, v;
    if (rst) begin
      foreach (m_cnt[u, k]) begin m_cnt[u][k] = 0; m_flag[u][k] = 0; end
      m_new = '0; m_rd = 0;
      return;
    end
    m_rd  = (int'(rd_class) < NC) ? m_cnt[rd_unit][rd_class] : 0;
    m_new = '0;
    if (clear_valid && clear_all) begin
      foreach (m_cnt[u, k]) begin m_cnt[u][k] = 0; m_flag[u][k] = 0; end
      return;
    end
    for (int u = 0; u < NU; u++) begin
      c = int'(evt_if.class_i[u]);
      if (!evt_if.valid_i[u] || c >= NC) continue;
      if (clear_valid && int'(clear_unit) == u && int'(clear_class) == c) continue;
      if (m_flag[u][c]) continue;
      if (evt_if.error_i[u]) v = (m_cnt[u][c] + M_INC > MAXC) ? MAXC : m_cnt[u][c] + M_INC;
      else                   v = (m_cnt[u][c] > M_DEC) ? m_cnt[u][c] - M_DEC : 0;
      m_cnt[u][c] = v;
      if (v >= M_THR) begin m_flag[u][c] = 1; m_new[u] = 1; end
    end
    if (clear_valid && int'(clear_class) < NC) begin
      m_cnt[clear_unit][clear_class]  = 0;
      m_flag[clear_unit][clear_class] = 0;
    end
  endtask

  function automatic logic [51:0] exp_vec();
    logic [35:0] f;
    logic [3:0] uf;
    f = '0; uf = '0;
    for (int u = 0; u < NU; u++)
      for (int k = 0; k < NC; k++) begin
        f[u*NC+k] = m_flag[u][k];
        uf[u] = uf[u] | m_flag[u][k];
      end
    return {f, uf, m_new, 8'(m_rd)};
  endfunction

  function automatic logic [51:0] dut_vec();
    return {faulty, unit_faulty, new_fault, rd_count};
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic set_idle();
    evt_if.valid_i = '0; evt_if.error_i = '0; evt_if.class_i = '0;
    clear_valid = 0; clear_all = 0; clear_unit = '0; clear_class = '0;
    sat_if.valid_i = '0; sat_if.error_i = '0; sat_if.class_i = '0;
  endtask

  task automatic test_reset();
    evt_if.valid_i = 4'($urandom); evt_if.error_i = 4'($urandom); evt_if.class_i = 16'($urandom);
    clear_valid = 1'($urandom); clear_all = 1'($urandom);
    rd_unit = 2'($urandom); rd_class = 4'($urandom);
    rst = 1;
    step(); step();
    n_checks++;
    if (dut_vec() !== 52'd0) $display("FAIL reset_outputs got %h exp 0", dut_vec());
    else n_pass++;
    n_checks++;
    if ({sat_faulty, sat_uf, sat_new, sat_rd} !== 12'd0)
      $display("FAIL reset_sat got %h exp 0", {sat_faulty, sat_uf, sat_new, sat_rd});
    else n_pass++;
    rst = 0; set_idle(); rd_unit = 3; rd_class = 8;
    step();
    n_checks++;
    if (rd_count !== 8'd0) $display("FAIL reset_read_3_8 got %0d exp 0", rd_count);
    else n_pass++;
  endtask

  task automatic test_threshold();
    set_idle(); rd_unit = 2; rd_class = 5;
    evt_if.valid_i = 4'b0100; evt_if.error_i = 4'b0100; evt_if.class_i[2] = 4'd5;
    repeat (99) begin
      step();
      n_checks++;
      if (dut_vec() !== exp_vec()) $display("FAIL thr_ramp got %h exp %h", dut_vec(), exp_vec());
      else n_pass++;
    end
    n_checks++;
    if (faulty[2][5] !== 1'b0) $display("FAIL thr_no_flag_at_99 got %b exp 0", faulty[2][5]);
    else n_pass++;
    step();
    n_checks++;
    if ({faulty[2][5], unit_faulty[2], new_fault, rd_count} !== {1'b1, 1'b1, 4'b0100, 8'd99})
      $display("FAIL thr_cross got f=%b uf=%b new=%b rd=%0d exp f=1 uf=1 new=0100 rd=99",
               faulty[2][5], unit_faulty[2], new_fault, rd_count);
    else n_pass++;
    evt_if.valid_i = '0;
    step();
    n_checks++;
    if ({new_fault, rd_count} !== {4'b0000, 8'd100})
      $display("FAIL thr_pulse_end got new=%b rd=%0d exp new=0000 rd=100", new_fault, rd_count);
    else n_pass++;
    evt_if.valid_i = 4'b0100;
    repeat (20) step();
    evt_if.valid_i = '0;
    step();
    n_checks++;
    if ({faulty[2][5], new_fault, rd_count} !== {1'b1, 4'b0000, 8'd100})
      $display("FAIL thr_frozen got f=%b new=%b rd=%0d exp f=1 new=0000 rd=100",
               faulty[2][5], new_fault, rd_count);
    else n_pass++;
  endtask

  task automatic test_leak();
    set_idle(); rd_unit = 0; rd_class = 1;
    evt_if.valid_i = 4'b0001; evt_if.class_i[0] = 4'd1;
    evt_if.error_i = 4'b0001; repeat (10) step();
    evt_if.error_i = 4'b0000; repeat (4) step();
    evt_if.valid_i = '0; step();
    n_checks++;
    if (rd_count !== 8'd2) $display("FAIL leak_10e_4c got %0d exp 2", rd_count);
    else n_pass++;
    evt_if.valid_i = 4'b0001; step();
    evt_if.valid_i = '0; step();
    n_checks++;
    if (rd_count !== 8'd0) $display("FAIL leak_floor got %0d exp 0", rd_count);
    else n_pass++;
    evt_if.valid_i = 4'b0001; step();
    evt_if.valid_i = '0; step();
    n_checks++;
    if (rd_count !== 8'd0) $display("FAIL leak_stay_zero got %0d exp 0", rd_count);
    else n_pass++;
  endtask

  task automatic test_saturation();
    set_idle(); sat_rd_unit = 0; sat_rd_class = 1;
    sat_if.valid_i = 2'b01; sat_if.error_i = 2'b01; sat_if.class_i[0] = 1'b1;
    step(); step();
    n_checks++;
    if (sat_faulty !== 4'b0000) $display("FAIL sat_no_flag_at_12 got %b exp 0000", sat_faulty);
    else n_pass++;
    step();
    n_checks++;
    if ({sat_faulty, sat_uf, sat_new, sat_rd} !== {4'b0010, 2'b01, 2'b01, 4'd12})
      $display("FAIL sat_cross got f=%b uf=%b new=%b rd=%0d exp f=0010 uf=01 new=01 rd=12",
               sat_faulty, sat_uf, sat_new, sat_rd);
    else n_pass++;
    sat_if.valid_i = '0; step();
    n_checks++;
    if (sat_rd !== 4'd15) $display("FAIL sat_value got %0d exp 15", sat_rd);
    else n_pass++;
  endtask

  task automatic test_clear();
    set_idle();
    evt_if.valid_i = 4'b0010; evt_if.error_i = 4'b0010; evt_if.class_i[1] = 4'd3;
    repeat (100) step();
    n_checks++;
    if (faulty[1][3] !== 1'b1) $display("FAIL clr_setup_flag got %b exp 1", faulty[1][3]);
    else n_pass++;
    evt_if.valid_i = 4'b0011; evt_if.error_i = 4'b0011; evt_if.class_i[0] = 4'd3;
    clear_valid = 1; clear_unit = 1; clear_class = 3;
    step();
    n_checks++;
    if ({faulty[1][3], unit_faulty[1], new_fault} !== {1'b0, 1'b0, 4'b0000})
      $display("FAIL clr_priority got f=%b uf=%b new=%b exp f=0 uf=0 new=0000",
               faulty[1][3], unit_faulty[1], new_fault);
    else n_pass++;
    set_idle(); rd_unit = 1; rd_class = 3; step();
    n_checks++;
    if (rd_count !== 8'd0) $display("FAIL clr_entry_count got %0d exp 0", rd_count);
    else n_pass++;
    rd_unit = 0; rd_class = 3; step();
    n_checks++;
    if (rd_count !== 8'd1) $display("FAIL clr_other_unit got %0d exp 1", rd_count);
    else n_pass++;
    clear_valid = 1; clear_all = 1; step();
    n_checks++;
    if ({faulty, unit_faulty, new_fault} !== 44'd0)
      $display("FAIL clr_all_flags got %h exp 0", {faulty, unit_faulty, new_fault});
    else n_pass++;
    set_idle(); rd_unit = 2; rd_class = 5; step();
    n_checks++;
    if (rd_count !== 8'd0) $display("FAIL clr_all_count got %0d exp 0", rd_count);
    else n_pass++;
  endtask

  task automatic test_parallel();
    logic [1:0] ru [4];
    logic [3:0] rc [4];
    logic [7:0] re [4];
    ru = '{2'd0, 2'd1, 2'd2, 2'd3};
    rc = '{4'd0, 4'd4, 4'd8, 4'd15};
    re = '{8'd1, 8'd1, 8'd1, 8'd0};
    set_idle();
    evt_if.valid_i = 4'b1111; evt_if.error_i = 4'b1111;
    for (int u = 0; u < 4; u++) evt_if.class_i[u] = rc[u];
    step();
    set_idle();
    for (int i = 0; i < 4; i++) begin
      rd_unit = ru[i]; rd_class = rc[i]; step();
      n_checks++;
      if (rd_count !== re[i]) $display("FAIL par_entry_%0d got %0d exp %0d", i, rd_count, re[i]);
      else n_pass++;
    end
    n_checks++;
    if (dut_vec() !== exp_vec()) $display("FAIL par_state got %h exp %h", dut_vec(), exp_vec());
    else n_pass++;
  endtask

  task automatic test_random();
    set_idle();
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 999) == 0);
      for (int u = 0; u < NU; u++) begin
        evt_if.valid_i[u] = ($urandom_range(0, 3) != 0);
        evt_if.error_i[u] = ($urandom_range(0, 9) < 8);
        evt_if.class_i[u] = ($urandom_range(0, 9) < 9) ? 4'($urandom_range(0, 3))
                                                      : 4'($urandom_range(9, 15));
      end
      clear_valid = ($urandom_range(0, 63) == 0);
      clear_all   = ($urandom_range(0, 7) == 0);
      clear_unit  = 2'($urandom);
      clear_class = 4'($urandom_range(0, 10));
      rd_unit     = 2'($urandom);
      rd_class    = 4'($urandom_range(0, 10));
      step();
      n_checks++;
      if (dut_vec() !== exp_vec())
        $display("FAIL rand_cycle_%0d got %h exp %h", n, dut_vec(), exp_vec());
      else n_pass++;
    end
    rst = 0;
  endtask

  initial begin
    rst = 1;
    rd_unit = '0; rd_class = '0; sat_rd_unit = 0; sat_rd_class = 0;
    set_idle();
    test_reset();
    test_threshold();
    test_leak();
    test_saturation();
    test_clear();
    test_parallel();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
